avg_accum_p: RTL and testbench

- Parametrised successor to the team's fixed 8-sample / 8-bit averaging circuit.
- Accumulates N = 2**LOG2N samples of DW bits, arriving under a valid/ready handshake, after a start pulse.
- Outputs the full-precision sum and the mean (truncated or rounded, selected by parameter).
- Sits between a sample source and downstream logic as a datapath + FSM block.

---
 rtl/avg_pkg.sv | 22 ++
 rtl/avg_datapath.sv | 66 ++++++
 rtl/avg_accum_p.sv | 94 +++++++++
 tb/tb_avg_accum_p.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared types and arithmetic helper for the parametrised averaging block.
package avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Divide a sum by 2**log2n, optionally rounding half up.
  // Worked in 64 bits so the bias add can never wrap for any sane width;
  // callers truncate the result back to their sample width.
  function automatic logic [63:0] round_shift(input logic [63:0] sum,
                                              input int          log2n,
                                              input logic        rnd);
    logic [63:0] bias;
    bias = 64'd0;
    if (rnd && (log2n > 0)) bias = 64'd1 << (log2n - 1);
    return (sum + bias) >> log2n;
  endfunction

endpackage

// File: rtl/avg_datapath.sv
// Accumulator, sample counter and result registers for avg_accum_p.
module avg_datapath #(
  parameter int DW    = 8,
  parameter int LOG2N = 3,
  parameter int ROUND = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic                  load_res,
  input  logic [DW-1:0]         din,
  output logic [LOG2N-1:0]      cnt,
  output logic [DW+LOG2N-1:0]   sum,
  output logic [DW-1:0]         avg
);
  import avg_pkg::*;

  localparam int SW = DW + LOG2N;

  logic [SW-1:0]    acc_q, acc_d, acc_next;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [DW-1:0]    avg_q, avg_d;

  // Next accumulator/counter/result values; results capture the total
  // including the sample accepted on the same edge.
  always_comb begin
    acc_next = acc_q + SW'(din);
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (acc_en) begin
      acc_d = acc_next;
      cnt_d = cnt_q + LOG2N'(1);
    end
    if (load_res) begin
      sum_d = acc_next;
      avg_d = DW'(round_shift(64'(acc_next), LOG2N, ROUND != 0));
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign cnt = cnt_q;
  assign sum = sum_q;
  assign avg = avg_q;

endmodule

// File: rtl/avg_accum_p.sv
// Averaging block: collects 2**LOG2N samples after start, reports sum and mean.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// ACCUM | accepting samples on din_valid until the last one
// DONE  | one cycle, results fresh; start here chains a new run
module avg_accum_p #(
  parameter int DW    = 8,
  parameter int LOG2N = 3,
  parameter int ROUND = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DW-1:0]       din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [LOG2N-1:0]    cnt,
  output logic [DW+LOG2N-1:0] sum,
  output logic [DW-1:0]       avg
);
  import avg_pkg::*;

  // Sample counter value while the final sample of a run is being offered.
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  state_t state_q, state_d;
  logic   clr, acc_en, load_res;

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    acc_en   = 1'b0;
    load_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (din_valid) begin
          acc_en = 1'b1;
          if (cnt == CNT_LAST) begin
            load_res = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign busy      = (state_q == ACCUM);
  assign din_ready = busy;
  assign done      = (state_q == DONE);
  assign ready     = (state_q == IDLE) || (state_q == DONE);

  avg_datapath #(
    .DW    (DW),
    .LOG2N (LOG2N),
    .ROUND (ROUND)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .acc_en   (acc_en),
    .load_res (load_res),
    .din      (din),
    .cnt      (cnt),
    .sum      (sum),
    .avg      (avg)
  );

endmodule

// File: tb/tb_avg_accum_p.sv
// Directed bench for avg_accum_p: truncating and rounding instances at
// DW=8/LOG2N=3 driven in lockstep, plus DW=12/LOG2N=4 and LOG2N=1 instances.
module tb_avg_accum_p;

  logic clk;
  logic rst;

  // DW=8, LOG2N=3: index 0 is ROUND=0, index 1 is ROUND=1
  logic       start_a, valid_a;
  logic [7:0] din_a;
  logic [1:0] ready_a, busy_a, done_a, drdy_a;
  logic [2:0] cnt_a [2];
  logic [10:0] sum_a [2];
  logic [7:0] avg_a [2];

  // DW=12, LOG2N=4, ROUND=0
  logic        start_c, valid_c;
  logic [11:0] din_c;
  logic        ready_c, busy_c, done_c, drdy_c;
  logic [3:0]  cnt_c;
  logic [15:0] sum_c;
  logic [11:0] avg_c;

  // DW=8, LOG2N=1: index 0 is ROUND=0, index 1 is ROUND=1
  logic       start_d, valid_d;
  logic [7:0] din_d;
  logic [1:0] ready_d, busy_d, done_d, drdy_d;
  logic [0:0] cnt_d [2];
  logic [8:0] sum_d [2];
  logic [7:0] avg_d [2];

  logic [7:0] smp [8];
  int checks = 0;
  int errors = 0;

  avg_accum_p #(.DW(8), .LOG2N(3), .ROUND(0)) u_a0 (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .din_valid(valid_a),
    .din_ready(drdy_a[0]), .ready(ready_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .cnt(cnt_a[0]), .sum(sum_a[0]), .avg(avg_a[0]));

  avg_accum_p #(.DW(8), .LOG2N(3), .ROUND(1)) u_a1 (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .din_valid(valid_a),
    .din_ready(drdy_a[1]), .ready(ready_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .cnt(cnt_a[1]), .sum(sum_a[1]), .avg(avg_a[1]));

  avg_accum_p #(.DW(12), .LOG2N(4), .ROUND(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .din(din_c), .din_valid(valid_c),
    .din_ready(drdy_c), .ready(ready_c), .busy(busy_c), .done(done_c),
    .cnt(cnt_c), .sum(sum_c), .avg(avg_c));

  avg_accum_p #(.DW(8), .LOG2N(1), .ROUND(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start_d), .din(din_d), .din_valid(valid_d),
    .din_ready(drdy_d[0]), .ready(ready_d[0]), .busy(busy_d[0]), .done(done_d[0]),
    .cnt(cnt_d[0]), .sum(sum_d[0]), .avg(avg_d[0]));

  avg_accum_p #(.DW(8), .LOG2N(1), .ROUND(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_d), .din(din_d), .din_valid(valid_d),
    .din_ready(drdy_d[1]), .ready(ready_d[1]), .busy(busy_d[1]), .done(done_d[1]),
    .cnt(cnt_d[1]), .sum(sum_d[1]), .avg(avg_d[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic r, input logic b,
                         input logic d, input logic dr);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ready"},     64'(ready_a[k]), 64'(r));
      chk({tag, "_busy"},      64'(busy_a[k]),  64'(b));
      chk({tag, "_done"},      64'(done_a[k]),  64'(d));
      chk({tag, "_din_ready"}, 64'(drdy_a[k]),  64'(dr));
    end
  endtask

  task automatic chk_res(input string tag, input logic [63:0] esum,
                         input logic [63:0] eavg0, input logic [63:0] eavg1);
    chk({tag, "_sum_r0"}, 64'(sum_a[0]), esum);
    chk({tag, "_sum_r1"}, 64'(sum_a[1]), esum);
    chk({tag, "_avg_r0"}, 64'(avg_a[0]), eavg0);
    chk({tag, "_avg_r1"}, 64'(avg_a[1]), eavg1);
  endtask

  // One full run on the DW=8/LOG2N=3 pair; ends in the DONE cycle.
  task automatic run_a(input string tag, input logic [7:0] gaps, input logic poke_start,
                       input logic [63:0] esum, input logic [63:0] eavg0,
                       input logic [63:0] eavg1);
    start_a = 1'b1;
    valid_a = 1'b0;
    tick();
    start_a = 1'b0;
    chk_ctl({tag, "_accum"}, 1'b0, 1'b1, 1'b0, 1'b1);
    chk({tag, "_cnt_clr"}, 64'(cnt_a[0]), 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        valid_a = 1'b0;
        din_a   = 8'h5A;
        start_a = poke_start;
        tick();
        start_a = 1'b0;
        chk({tag, "_gap_cnt"},  64'(cnt_a[0]),  64'(i));
        chk({tag, "_gap_busy"}, 64'(busy_a[0]), 64'd1);
      end
      valid_a = 1'b1;
      din_a   = smp[i];
      tick();
      valid_a = 1'b0;
      if (i < 7) begin
        chk({tag, "_cnt"},       64'(cnt_a[1]), 64'(i + 1));
        chk({tag, "_no_done"},   64'(done_a[0]), 64'd0);
      end
    end
    chk_ctl({tag, "_fin"}, 1'b1, 1'b0, 1'b1, 1'b0);
    chk({tag, "_cnt_wrap0"}, 64'(cnt_a[0]), 64'd0);
    chk({tag, "_cnt_wrap1"}, 64'(cnt_a[1]), 64'd0);
    chk_res(tag, esum, eavg0, eavg1);
  endtask

  initial begin
    logic seen_done;
    rst     = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; din_a = 8'h00;
    start_c = 1'b0; valid_c = 1'b0; din_c = 12'h000;
    start_d = 1'b0; valid_d = 1'b0; din_d = 8'h00;
    tick();
    tick();
    chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_res("reset", 64'd0, 64'd0, 64'd0);
    chk("reset_cnt", 64'(cnt_a[0]), 64'd0);
    rst = 1'b0;

    // samples offered while idle must not be taken
    valid_a = 1'b1;
    din_a   = 8'hFF;
    tick();
    tick();
    valid_a = 1'b0;
    chk("idle_cnt", 64'(cnt_a[0]), 64'd0);
    chk_ctl("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    smp = '{8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF};
    run_a("basic", 8'h00, 1'b0, 64'h6A4, 64'hD4, 64'hD5);
    tick();
    chk_ctl("post_basic", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_res("hold", 64'h6A4, 64'hD4, 64'hD5);

    run_a("gapped", 8'b0110_1001, 1'b1, 64'h6A4, 64'hD4, 64'hD5);
    tick();

    smp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_a("zeros", 8'h00, 1'b0, 64'h0, 64'h0, 64'h0);
    tick();

    // back-to-back: second run started from the DONE cycle
    smp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_a("ones", 8'h00, 1'b0, 64'h7F8, 64'hFF, 64'hFF);
    smp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_a("b2b", 8'h00, 1'b0, 64'h8, 64'h1, 64'h1);
    tick();

    // reset after five samples discards the run and clears results
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_a = 1'b1;
      din_a   = 8'h40;
      tick();
    end
    valid_a = 1'b0;
    chk("midrst_cnt5", 64'(cnt_a[0]), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_res("midrst", 64'd0, 64'd0, 64'd0);
    chk("midrst_cnt", 64'(cnt_a[0]), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_a = 1'b1;
      din_a   = 8'h40;
      tick();
      seen_done = seen_done | done_a[0] | done_a[1];
    end
    valid_a = 1'b0;
    chk("midrst_no_done", 64'(seen_done), 64'd0);

    smp = '{8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF};
    run_a("fresh", 8'h24, 1'b0, 64'h6A4, 64'hD4, 64'hD5);
    tick();

    // DW=12, LOG2N=4: sixteen full-scale samples
    chk("c_idle_ready", 64'(ready_c), 64'd1);
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("c_busy", 64'(busy_c), 64'd1);
    chk("c_din_ready", 64'(drdy_c), 64'd1);
    for (int i = 0; i < 16; i++) begin
      valid_c = 1'b1;
      din_c   = 12'hFFF;
      tick();
      if (i == 14) chk("c_no_done", 64'(done_c), 64'd0);
    end
    valid_c = 1'b0;
    chk("c_done", 64'(done_c), 64'd1);
    chk("c_sum", 64'(sum_c), 64'hFFF0);
    chk("c_avg", 64'(avg_c), 64'hFFF);
    chk("c_cnt", 64'(cnt_c), 64'd0);
    tick();
    chk("c_idle_done", 64'(done_c), 64'd0);

    // DW=8, LOG2N=1: samples 3,4 -> 7, mean 3.5
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    chk("d_busy0", 64'(busy_d[0]), 64'd1);
    chk("d_busy1", 64'(busy_d[1]), 64'd1);
    chk("d_din_ready", 64'(drdy_d), 64'd3);
    valid_d = 1'b1;
    din_d   = 8'd3;
    tick();
    chk("d_cnt1", 64'(cnt_d[0]), 64'd1);
    chk("d_no_done", 64'(done_d), 64'd0);
    din_d = 8'd4;
    tick();
    valid_d = 1'b0;
    chk("d_done", 64'(done_d), 64'd3);
    chk("d_ready", 64'(ready_d), 64'd3);
    chk("d_cnt_wrap", 64'(cnt_d[1]), 64'd0);
    chk("d_sum_r0", 64'(sum_d[0]), 64'd7);
    chk("d_sum_r1", 64'(sum_d[1]), 64'd7);
    chk("d_avg_r0", 64'(avg_d[0]), 64'd3);
    chk("d_avg_r1", 64'(avg_d[1]), 64'd4);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
